// File: rtl/dram_arbiter.sv
// Arbitrates the DRAM sequencer between port 0 (CPU), port 1 (DMA/video) and refresh.
// Define ARB_WATCHDOG_EN to add a BUSY/REFRESH timeout that reports ERR.
module dram_arbiter #(
    parameter int ADDR_W     = 28,
    parameter int CPU_MAX    = 4,
    parameter int WDT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              rw0,
    input  logic              rw1,
    input  logic [1:0]        siz0,
    input  logic [1:0]        siz1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              err,
    input  logic              ref_req,
    output logic              ref_ack,
    output logic              mem_start,
    output logic              mem_ref,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rw,
    output logic [1:0]        mem_siz,
    input  logic              mem_done
);

    localparam int STARVE_W = (CPU_MAX < 1) ? 1 : $clog2(CPU_MAX + 1);

    typedef enum logic [1:0] {IDLE, BUSY, REFRESH, RECOVER} state_t;
    typedef enum logic [1:0] {OP_NONE, OP_PORT0, OP_PORT1, OP_REF} op_t;

    state_t              state;
    state_t              state_next;
    op_t                 pick;
    op_t                 op;
    logic [STARVE_W-1:0] starve;
    logic                in_op;
    logic                timeout;
    logic                timed_out;

    assign in_op = (state == BUSY) || (state == REFRESH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Arbitration only happens in IDLE; a starved port 1 overtakes port 0.
    always_comb begin
        pick       = OP_NONE;
        state_next = state;
        case (state)
            IDLE: begin
                if (ref_req) begin
                    pick = OP_REF;
                end else if (req1 && (starve == STARVE_W'(CPU_MAX))) begin
                    pick = OP_PORT1;
                end else if (req0) begin
                    pick = OP_PORT0;
                end else if (req1) begin
                    pick = OP_PORT1;
                end
                if (pick == OP_REF) begin
                    state_next = REFRESH;
                end else if (pick != OP_NONE) begin
                    state_next = BUSY;
                end
            end
            BUSY, REFRESH: begin
                if (mem_done || timeout) begin
                    state_next = RECOVER;
                end
            end
            RECOVER: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        done0   = 1'b0;
        done1   = 1'b0;
        ref_ack = 1'b0;
        err     = 1'b0;
        mem_ref = (state == REFRESH);
        if (in_op || (state == RECOVER)) begin
            gnt0 = (op == OP_PORT0);
            gnt1 = (op == OP_PORT1);
        end
        if (state == RECOVER) begin
            done0   = (op == OP_PORT0);
            done1   = (op == OP_PORT1);
            ref_ack = (op == OP_REF);
            err     = timed_out;
        end
    end

    // Request attributes are captured once at grant and held for the whole operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            op        <= OP_NONE;
            mem_start <= 1'b0;
            mem_addr  <= '0;
            mem_rw    <= 1'b1;
            mem_siz   <= '0;
            starve    <= '0;
        end else begin
            mem_start <= (pick != OP_NONE);
            if (pick != OP_NONE) begin
                op <= pick;
            end
            if (pick == OP_PORT0) begin
                mem_addr <= addr0;
                mem_rw   <= rw0;
                mem_siz  <= siz0;
            end else if (pick == OP_PORT1) begin
                mem_addr <= addr1;
                mem_rw   <= rw1;
                mem_siz  <= siz1;
            end
            if (state == IDLE) begin
                if (!req1 || (pick == OP_PORT1)) begin
                    starve <= '0;
                end else if ((pick == OP_PORT0) && (starve != STARVE_W'(CPU_MAX))) begin
                    starve <= starve + 1'b1;
                end
            end
        end
    end

`ifdef ARB_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);

    logic [WDT_W-1:0] wdt_count;

    // Counter is zero on the MEM_START cycle, so the timeout lands WDT_CYCLES after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_count <= '0;
            timed_out <= 1'b0;
        end else begin
            wdt_count <= in_op ? wdt_count + 1'b1 : '0;
            timed_out <= in_op && timeout;
        end
    end

    assign timeout = (wdt_count == WDT_W'(WDT_CYCLES - 1)) && !mem_done;
`else
    logic unused_wdt;

    assign unused_wdt = WDT_CYCLES[0];
    assign timeout    = 1'b0;
    assign timed_out  = 1'b0;
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: a cycle-timeline reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_dram_arbiter;

    localparam int ADDR_W     = 28;
    localparam int CPU_MAX    = 4;
    localparam int WDT_CYCLES = 8;
    localparam int NEVER      = 32'h7fff_ffff;
    localparam int EV_START   = 0;
    localparam int EV_DONE0   = 1;
    localparam int EV_DONE1   = 2;
    localparam int EV_REFACK  = 3;
`ifdef ARB_WATCHDOG_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              req0, req1, rw0, rw1, ref_req;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [1:0]        siz0, siz1;
    logic              gnt0, gnt1, done0, done1, err, ref_ack;
    logic              mem_start, mem_ref, mem_rw, mem_done;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_siz;
    logic              seq_done, manual_done;

    int checks = 0;
    int errors = 0;

    assign mem_done = seq_done | manual_done;

    dram_arbiter #(
        .ADDR_W    (ADDR_W),
        .CPU_MAX   (CPU_MAX),
        .WDT_CYCLES(WDT_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .addr0    (addr0),
        .addr1    (addr1),
        .rw0      (rw0),
        .rw1      (rw1),
        .siz0     (siz0),
        .siz1     (siz1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .done0    (done0),
        .done1    (done1),
        .err      (err),
        .ref_req  (ref_req),
        .ref_ack  (ref_ack),
        .mem_start(mem_start),
        .mem_ref  (mem_ref),
        .mem_addr (mem_addr),
        .mem_rw   (mem_rw),
        .mem_siz  (mem_siz),
        .mem_done (mem_done)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic probe(input int which);
        case (which)
            EV_START:  return mem_start;
            EV_DONE0:  return done0;
            EV_DONE1:  return done1;
            EV_REFACK: return ref_ack;
            default:   return err;
        endcase
    endfunction

    task automatic waitFor(input string name, input int which, input int limit, output int waited);
        waited = 0;
        while (probe(which) == 1'b0 && waited < limit) begin
            @(negedge clk);
            waited++;
        end
        if (probe(which) == 1'b0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: event not seen within %0d cycles", name, limit);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic r1, input logic rf);
        req0    = r0;
        req1    = r1;
        ref_req = rf;
    endtask

    // Reference model: each operation is a window [start, end] of cycle numbers.
    int                cyc      = 0;
    int                m_owner  = -1;
    int                m_start  = NEVER;
    int                m_end    = NEVER;
    bit                m_timed  = 1'b0;
    int                m_starve = 0;
    logic [ADDR_W-1:0] m_addr   = '0;
    logic              m_rw     = 1'b1;
    logic [1:0]        m_siz    = 2'b00;

    always @(posedge clk) begin
        int now;
        int win;
        now = cyc;
        cyc = cyc + 1;
        if (rst) begin
            m_owner  = -1;
            m_start  = NEVER;
            m_end    = NEVER;
            m_timed  = 1'b0;
            m_starve = 0;
            m_addr   = '0;
            m_rw     = 1'b1;
            m_siz    = 2'b00;
        end else if (m_owner < 0 || (m_end != NEVER && now > m_end)) begin
            win = -1;
            if (ref_req) win = 2;
            else if (req1 && m_starve == CPU_MAX) win = 1;
            else if (req0) win = 0;
            else if (req1) win = 1;
            if (!req1 || win == 1) m_starve = 0;
            else if (win == 0 && m_starve < CPU_MAX) m_starve = m_starve + 1;
            m_owner = win;
            m_start = (win >= 0) ? now + 1 : NEVER;
            m_end   = NEVER;
            m_timed = 1'b0;
            if (win == 0) begin
                m_addr = addr0; m_rw = rw0; m_siz = siz0;
            end else if (win == 1) begin
                m_addr = addr1; m_rw = rw1; m_siz = siz1;
            end
        end else if (m_end == NEVER && now >= m_start) begin
            if (mem_done) begin
                m_end = now + 1;
            end else if (WDT_ON && (now - m_start + 1 == WDT_CYCLES)) begin
                m_end   = now + 1;
                m_timed = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] exp_ctrl;
        logic [7:0] got_ctrl;
        bit         window;
        if (cyc > 0) begin
            window   = (m_owner >= 0) && (cyc >= m_start) && (cyc <= m_end);
            exp_ctrl = {window && m_owner == 0, window && m_owner == 1,
                        m_owner == 0 && cyc == m_end, m_owner == 1 && cyc == m_end,
                        m_timed && cyc == m_end, m_owner == 2 && cyc == m_end,
                        m_owner >= 0 && cyc == m_start,
                        m_owner == 2 && cyc >= m_start && cyc < m_end};
            got_ctrl = {gnt0, gnt1, done0, done1, err, ref_ack, mem_start, mem_ref};
            checkOutput($sformatf("ctrl@%0d", cyc), 32'(got_ctrl), 32'(exp_ctrl));
            checkOutput($sformatf("mem@%0d", cyc), 32'({mem_addr, mem_rw, mem_siz}),
                        32'({m_addr, m_rw, m_siz}));
        end
    end

    // Sequencer stand-in: MEM_DONE seq_lat cycles after each MEM_START, and a grant log.
    int seq_lat = 3;
    bit seq_en  = 1'b1;
    int seq_cnt = -1;
    int grant_log[$];

    always @(negedge clk) begin
        seq_done = 1'b0;
        if (rst) begin
            seq_cnt = -1;
        end else if (seq_cnt > 0) begin
            seq_cnt = seq_cnt - 1;
            if (seq_cnt == 0) begin
                seq_done = 1'b1;
                seq_cnt  = -1;
            end
        end
        if (mem_start) begin
            grant_log.push_back(gnt1 ? 1 : (mem_ref ? 2 : 0));
            if (seq_en) seq_cnt = seq_lat;
        end
    end

    int exp_order[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    initial begin
        int w;
        int base;
        int n_err, n_done, n_start, err_at;
        rst = 1'b1; manual_done = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        addr0 = '0; addr1 = '0; rw0 = 1'b1; rw1 = 1'b1; siz0 = 2'b00; siz1 = 2'b00;
        repeat (2) @(negedge clk);
        checkOutput("reset_gnt", 32'({gnt0, gnt1}), 0);
        checkOutput("reset_start", 32'(mem_start), 0);
        checkOutput("reset_rw", 32'(mem_rw), 1);
        checkOutput("reset_addr", 32'(mem_addr), 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single port-0 read");
        seq_lat = 6; addr0 = 28'h0000100; rw0 = 1'b1; siz0 = 2'b00;
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t1_start", 32'(mem_start), 1);
        checkOutput("t1_gnt0", 32'(gnt0), 1);
        checkOutput("t1_addr", 32'(mem_addr), 32'h100);
        waitFor("t1_done0", EV_DONE0, 20, w);
        checkOutput("t1_done_latency", 32'(w), 7);
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t1_gnt0_released", 32'(gnt0), 0);
        repeat (2) @(negedge clk);

        $display("[TB] fairness with both ports requesting");
        seq_lat = 2; addr1 = 28'h0000A00; rw1 = 1'b0; siz1 = 2'b10;
        base = grant_log.size();
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 80 && grant_log.size() < base + 10; k++) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        if (grant_log.size() < base + 10) begin
            checkOutput("t2_grant_count", 32'(grant_log.size() - base), 10);
        end else begin
            for (int i = 0; i < 10; i++)
                checkOutput($sformatf("t2_grant%0d", i), 32'(grant_log[base + i]), 32'(exp_order[i]));
        end
        waitFor("t2_done1", EV_DONE1, 10, w);
        repeat (3) @(negedge clk);

        $display("[TB] refresh queued behind port 1, ahead of port 0");
        seq_lat = 4; addr1 = 28'h0ABCDE0; rw1 = 1'b0; siz1 = 2'b11;
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitFor("t3_start1", EV_START, 5, w);
        checkOutput("t3_gnt1", 32'(gnt1), 1);
        @(negedge clk);
        addr0 = 28'h0000200; rw0 = 1'b1; siz0 = 2'b01;
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitFor("t3_done1", EV_DONE1, 10, w);
        applyStimulus(1'b1, 1'b0, 1'b1);
        waitFor("t3_start_ref", EV_START, 6, w);
        checkOutput("t3_mem_ref", 32'(mem_ref), 1);
        checkOutput("t3_gnt0_held_off", 32'(gnt0), 0);
        waitFor("t3_ref_ack", EV_REFACK, 10, w);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitFor("t3_start0", EV_START, 6, w);
        checkOutput("t3_gnt0", 32'(gnt0), 1);
        checkOutput("t3_addr0", 32'(mem_addr), 32'h200);
        checkOutput("t3_siz0", 32'(mem_siz), 1);
        waitFor("t3_done0", EV_DONE0, 10, w);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        $display("[TB] reset in the middle of an operation");
        seq_en = 1'b0; addr0 = 28'h0000300; rw0 = 1'b0; siz0 = 2'b10;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitFor("t4_start", EV_START, 5, w);
        checkOutput("t4_rw_latched", 32'(mem_rw), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t4_gnt_cleared", 32'({gnt0, gnt1}), 0);
        checkOutput("t4_rw_reset", 32'(mem_rw), 1);
        checkOutput("t4_addr_reset", 32'(mem_addr), 0);
        n_done = 0;
        for (int k = 0; k < 6; k++) begin
            if (done0) n_done++;
            @(negedge clk);
        end
        checkOutput("t4_no_done", 32'(n_done), 0);
        seq_en = 1'b1; seq_lat = 3; addr0 = 28'h0000380;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitFor("t4_restart", EV_START, 5, w);
        checkOutput("t4_new_addr", 32'(mem_addr), 32'h380);
        waitFor("t4_done0", EV_DONE0, 10, w);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        $display("[TB] MEM_DONE withheld");
        seq_en = 1'b0; addr0 = 28'h0000400;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitFor("t5_start", EV_START, 5, w);
        n_err = 0; n_done = 0; err_at = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (err) begin n_err++; err_at = k; end
            if (done0) begin n_done++; req0 = 1'b0; end
        end
`ifdef ARB_WATCHDOG_EN
        checkOutput("t5_err_count", 32'(n_err), 1);
        checkOutput("t5_err_at", 32'(err_at), 8);
        checkOutput("t5_done_count", 32'(n_done), 1);
        checkOutput("t5_gnt0_released", 32'(gnt0), 0);
`else
        checkOutput("t5_err_count", 32'(n_err), 0);
        checkOutput("t5_done_count", 32'(n_done), 0);
        checkOutput("t5_gnt0_held", 32'(gnt0), 1);
`endif
        manual_done = 1'b1;
        @(negedge clk);
        manual_done = 1'b0;
        n_done = 0;
        for (int k = 0; k < 4; k++) begin
            if (done0) begin n_done++; req0 = 1'b0; end
            @(negedge clk);
        end
        checkOutput("t5_late_done", 32'(n_done), WDT_ON ? 0 : 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        seq_en = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] REQ0 dropped right after grant");
        seq_lat = 3; addr0 = 28'h0000500;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitFor("t6_start", EV_START, 5, w);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        n_done = 0; n_start = 0;
        for (int k = 0; k < 10; k++) begin
            if (done0) n_done++;
            if (mem_start) n_start++;
            @(negedge clk);
        end
        checkOutput("t6_done_once", 32'(n_done), 1);
        checkOutput("t6_no_regrant", 32'(n_start), 0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

endmodule
